vc_rr_sel: RTL and testbench

VC_RR_SEL -- requirements
Module: vc_rr_sel

---
 rtl/vc_rr_sel.sv | 176 +++++++++++++++++
 tb/tb_vc_rr_sel.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vc_rr_sel.sv
// vc_rr_sel: per-input-port round-robin VC selector feeding the switch allocator.
// Offers one requesting VC (sel/sel_valid, both registered), holds it until the
// allocator grants it, locks it for the rest of a multi-flit packet, then moves
// the round-robin pointer past the VC that just finished.
// Optional starvation timeout: define VC_SEL_TIMEOUT_EN to reselect after TIMEOUT
// HOLD cycles without a grant; without it TIMEOUT is only range-checked.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | nothing selected, sel_valid low
// ST_HOLD | sel offered to the allocator, no flit of it granted yet
// ST_LOCK | mid-packet: a non-tail flit of sel was granted, sel frozen

module vc_rr_sel #(
   parameter int NUM_VC         = 4,
   parameter int VC_INDEX_WIDTH = 2,
   parameter int TIMEOUT        = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_VC-1:0]         vc_valid,
   input  logic                      sa_grant,
   input  logic                      sa_tail,
   output logic [VC_INDEX_WIDTH-1:0] sel,
   output logic                      sel_valid
);

   if ((1 << VC_INDEX_WIDTH) != NUM_VC || NUM_VC < 2 || NUM_VC > 8) begin : g_bad_num_vc
      $error("vc_rr_sel: NUM_VC must be 2, 4 or 8 and equal 2**VC_INDEX_WIDTH");
   end
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("vc_rr_sel: TIMEOUT must be in 2..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [VC_INDEX_WIDTH-1:0] ptr_q, ptr_d;
   logic [VC_INDEX_WIDTH-1:0] sel_q, sel_d;
   logic                      sel_valid_q, sel_valid_d;
   logic [VC_INDEX_WIDTH-1:0] sel_inc;
   logic [VC_INDEX_WIDTH:0]   pick_ptr, pick_inc;
   logic                      grant_ok;
   logic                      advance;
   logic                      timeout_hit;

   // {found, index} of the first set request at or after start, wrapping.
   // Lowest offset wins because later loop iterations overwrite earlier ones.
   function automatic logic [VC_INDEX_WIDTH:0] rr_pick(
      input logic [NUM_VC-1:0]         req,
      input logic [VC_INDEX_WIDTH-1:0] start
   );
      logic                      found;
      logic [VC_INDEX_WIDTH-1:0] idx;
      logic [VC_INDEX_WIDTH-1:0] cand;
      found = 1'b0;
      idx   = start;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         cand = start + VC_INDEX_WIDTH'(i);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   assign sel_inc  = sel_q + VC_INDEX_WIDTH'(1);
   assign pick_ptr = rr_pick(vc_valid, ptr_q);
   // Reselection candidate computed under the advanced pointer so a new VC is
   // offered in the same cycle the old one is released.
   assign pick_inc = rr_pick(vc_valid, sel_inc);
   // A grant only means something while a valid selection is being offered.
   assign grant_ok = sa_grant & sel_valid_q;

`ifdef VC_SEL_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

   // Age of the current HOLD offer; any exit or reselection restarts it.
   always_comb begin
      cnt_d = 8'd0;
      if (state_q == ST_HOLD && !sa_grant && vc_valid[sel_q] && !timeout_hit) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // HOLD age counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, pointer and selection decision.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      sel_valid_d = sel_valid_q;
      advance     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|vc_valid) begin
               sel_d       = pick_ptr[VC_INDEX_WIDTH-1:0];
               sel_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else begin
               sel_valid_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (grant_ok && sa_tail) begin
               advance = 1'b1;
            end else if (grant_ok) begin
               state_d     = ST_LOCK;
               sel_valid_d = vc_valid[sel_q];
            end else if (!vc_valid[sel_q] || timeout_hit) begin
               advance = 1'b1;
            end
         end
         ST_LOCK: begin
            if (grant_ok && sa_tail) begin
               advance = 1'b1;
            end else begin
               // Packet bubbles keep the lock; only the offer drops.
               sel_valid_d = vc_valid[sel_q];
            end
         end
         default: begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
         end
      endcase
      if (advance) begin
         ptr_d = sel_inc;
         if (pick_inc[VC_INDEX_WIDTH]) begin
            sel_d       = pick_inc[VC_INDEX_WIDTH-1:0];
            sel_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end else begin
            sel_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      end
   end

   // FSM, pointer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         sel_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = sel_valid_q;

endmodule

// File: tb/tb_vc_rr_sel.sv
// Bench for vc_rr_sel: directed scenarios with fixed expectations, then random
// traffic compared against a behavioural model of the selection rules.
module tb_vc_rr_sel;

   localparam int NV = 4;
   localparam int TO = 4;
`ifdef VC_SEL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NV-1:0] vc_valid = '0;
   logic          sa_grant = 1'b0;
   logic          sa_tail = 1'b0;
   logic [1:0]    sel;
   logic          sel_valid;

   int n_cmp = 0;
   int n_mis = 0;

   // model: who is offered, whether a packet is in flight, age of the offer
   bit m_busy;
   bit m_locked;
   bit m_sv;
   int m_sel;
   int m_ptr;
   int m_age;

   vc_rr_sel #(.NUM_VC(NV), .VC_INDEX_WIDTH(2), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .vc_valid(vc_valid), .sa_grant(sa_grant),
      .sa_tail(sa_tail), .sel(sel), .sel_valid(sel_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int first_from(input logic [NV-1:0] v, input int p);
      for (int k = 0; k < NV; k++) begin
         if (v[(p + k) % NV]) return (p + k) % NV;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_locked = 0; m_sv = 0; m_sel = 0; m_ptr = 0; m_age = 0;
   endtask

   task automatic model_rotate(input logic [NV-1:0] v);
      m_ptr = (m_sel + 1) % NV;
      m_age = 0;
      m_locked = 0;
      if (v != 0) begin
         m_sel = first_from(v, m_ptr);
         m_sv = 1;
      end else begin
         m_busy = 0;
         m_sv = 0;
      end
   endtask

   task automatic model_clock(input logic [NV-1:0] v, input bit g, input bit t);
      bit granted;
      granted = g && m_sv;
      if (!m_busy) begin
         if (v != 0) begin
            m_sel = first_from(v, m_ptr);
            m_sv = 1; m_busy = 1; m_locked = 0; m_age = 0;
         end else begin
            m_sv = 0;
         end
      end else if (granted && t) begin
         model_rotate(v);
      end else if (m_locked) begin
         m_sv = v[m_sel];
      end else if (granted) begin
         m_locked = 1;
         m_sv = v[m_sel];
      end else if (!v[m_sel] || (TO_EN && m_age == TO - 1)) begin
         model_rotate(v);
      end else begin
         m_age++;
      end
   endtask

   // one clock with the given inputs, then compare DUT with the model
   task automatic step(input logic [NV-1:0] v, input bit g, input bit t);
      vc_valid = v; sa_grant = g; sa_tail = t;
      @(posedge clk);
      model_clock(v, g, t);
      #1;
      check("model_sel_valid", int'(sel_valid), int'(m_sv));
      if (m_sv) check("model_sel", int'(sel), m_sel);
   endtask

   task automatic expect_out(input string tag, input int exp_sv, input int exp_sel);
      check({tag, "_sel_valid"}, int'(sel_valid), exp_sv);
      check({tag, "_sel"}, int'(sel), exp_sel);
   endtask

   initial begin
      logic [NV-1:0] rv;
      bit rg, rt;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // two-VC rotation
      step(4'b0110, 0, 0); expect_out("r027_a", 1, 1);
      step(4'b0110, 1, 1); expect_out("r027_b", 1, 2);
      step(4'b0110, 1, 1); expect_out("r027_c", 1, 1);

      // offered VC withdraws
      step(4'b1000, 0, 0); expect_out("r032", 1, 3);

      // all requesting, tail every cycle
      step(4'b1111, 1, 1); expect_out("r028_0", 1, 0);
      step(4'b1111, 1, 1); expect_out("r028_1", 1, 1);
      step(4'b1111, 1, 1); expect_out("r028_2", 1, 2);
      step(4'b1111, 1, 1); expect_out("r028_3", 1, 3);
      step(4'b1111, 1, 1); expect_out("r028_4", 1, 0);

      // lock on VC2 with a bubble; grant during the bubble is ignored
      step(4'b0100, 1, 1); expect_out("r029_sel2", 1, 2);
      step(4'b0100, 1, 0); expect_out("r029_lock", 1, 2);
      step(4'b1011, 0, 0); expect_out("r029_bub0", 0, 2);
      step(4'b1011, 1, 1); expect_out("r029_bub1", 0, 2);
      step(4'b1011, 0, 0); expect_out("r029_bub2", 0, 2);
      step(4'b1111, 0, 0); expect_out("r029_back", 1, 2);
      step(4'b1111, 1, 1); expect_out("r029_next", 1, 3);

      // starvation timeout (or its absence)
      step(4'b0011, 0, 0); expect_out("r030_0", 1, 0);
      for (int k = 0; k < 3; k++) begin
         step(4'b0011, 0, 0); expect_out("r030_hold", 1, 0);
      end
      step(4'b0011, 0, 0); expect_out("r030_after", 1, TO_EN ? 1 : 0);

      // single requester re-offered with no gap
      step(4'b0100, 0, 0); expect_out("r021_a", 1, 2);
      step(4'b0100, 1, 1); expect_out("r021_b", 1, 2);
      step(4'b0000, 0, 0); check("drain_sel_valid", int'(sel_valid), 0);
      step(4'b0000, 1, 1); check("idle_grant_sel_valid", int'(sel_valid), 0);

      // asynchronous reset in LOCK on VC3
      step(4'b1000, 0, 0); expect_out("r031_sel3", 1, 3);
      step(4'b1000, 1, 0); expect_out("r031_lock", 1, 3);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("r031_async", 0, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("r023_no_early_sel", int'(sel_valid), 0);
      step(4'b1000, 0, 0); expect_out("r023_first", 1, 3);

      // random traffic against the model
      rv = 4'b1000;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
         rg = ($urandom_range(0, 2) == 0);
         rt = ($urandom_range(0, 1) == 0);
         step(rv, rg, rt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
